// File: rtl/team_04_pkg.sv
// rtl/team_04_pkg.sv - shared sizes and key-code helpers for the keypad scanner.
package team_04_pkg;

   localparam int N_ROWS = 4;
   localparam int N_COLS = 4;
   localparam int KEY_W  = 4;

   function automatic logic [KEY_W-1:0] encode_key(input logic [1:0] col, input logic [1:0] row);
      return KEY_W'(col) * KEY_W'(N_ROWS) + KEY_W'(row);
   endfunction

   // Lowest asserted row wins when several rows are active in one column.
   function automatic logic [1:0] first_row(input logic [N_ROWS-1:0] rows);
      logic [1:0] r;
      r = '0;
      for (int i = N_ROWS - 1; i >= 0; i--) begin
         if (rows[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/team_04_row_sync.sv
// rtl/team_04_row_sync.sv - two-flop synchroniser for the asynchronous keypad rows.
module team_04_row_sync
   import team_04_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [N_ROWS-1:0] row_in,
   output logic [N_ROWS-1:0] row_sync
);

   logic [N_ROWS-1:0] meta_q, meta_d;
   logic [N_ROWS-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = row_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign row_sync = sync_q;

endmodule

// File: rtl/team_04_keypad_scanner.sv
// rtl/team_04_keypad_scanner.sv - 4x4 keypad column scanner with frame-level debounce.
module team_04_keypad_scanner
   import team_04_pkg::*;
#(
   parameter int SCAN_DIV        = 4000,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [N_ROWS-1:0] row_in,
   output logic [N_COLS-1:0] col_out,
   output logic              key_valid,
   output logic [KEY_W-1:0]  key_code,
   output logic              key_held
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   logic [N_ROWS-1:0] row_s;

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic             frame_hit_q, frame_hit_d;
   logic [KEY_W-1:0] frame_code_q, frame_code_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic             key_valid_q, key_valid_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic             key_held_q, key_held_d;

   logic             tc;
   logic             f_hit;
   logic [KEY_W-1:0] f_code;

   team_04_row_sync u_row_sync (
      .clk      (clk),
      .rst      (rst),
      .row_in   (row_in),
      .row_sync (row_s)
   );

   always_comb begin
      div_d        = div_q;
      col_idx_d    = col_idx_q;
      frame_hit_d  = frame_hit_q;
      frame_code_d = frame_code_q;
      cand_d       = cand_q;
      stable_d     = stable_q;
      key_valid_d  = 1'b0;
      key_code_d   = key_code_q;
      key_held_d   = key_held_q;
      tc           = (div_q == DIV_W'(SCAN_DIV - 1));
      // First hit of the frame wins; the current column only counts if nothing was latched yet.
      f_hit        = frame_hit_q | (|row_s);
      f_code       = frame_hit_q ? frame_code_q : encode_key(col_idx_q, first_row(row_s));

      if (!en) begin
         div_d        = '0;
         col_idx_d    = '0;
         frame_hit_d  = 1'b0;
         frame_code_d = '0;
         cand_d       = '0;
         stable_d     = '0;
         key_code_d   = '0;
         key_held_d   = 1'b0;
      end else if (tc) begin
         div_d     = '0;
         col_idx_d = col_idx_q + 2'd1;
         if (col_idx_q == 2'd3) begin
            frame_hit_d  = 1'b0;
            frame_code_d = '0;
            cand_d       = f_hit ? f_code : '0;
            if (!f_hit) begin
               stable_d   = '0;
               key_held_d = 1'b0;
            end else if (stable_q != '0 && f_code == cand_q) begin
               if (stable_q != CNT_W'(DEBOUNCE_FRAMES)) stable_d = stable_q + CNT_W'(1);
            end else begin
               stable_d   = CNT_W'(1);
               key_held_d = 1'b0;
            end
         end else begin
            frame_hit_d  = f_hit;
            frame_code_d = f_code;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
         if (stable_q == CNT_W'(DEBOUNCE_FRAMES) && !key_held_q) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_q;
            key_held_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q        <= '0;
         col_idx_q    <= '0;
         frame_hit_q  <= 1'b0;
         frame_code_q <= '0;
         cand_q       <= '0;
         stable_q     <= '0;
         key_valid_q  <= 1'b0;
         key_code_q   <= '0;
         key_held_q   <= 1'b0;
      end else begin
         div_q        <= div_d;
         col_idx_q    <= col_idx_d;
         frame_hit_q  <= frame_hit_d;
         frame_code_q <= frame_code_d;
         cand_q       <= cand_d;
         stable_q     <= stable_d;
         key_valid_q  <= key_valid_d;
         key_code_q   <= key_code_d;
         key_held_q   <= key_held_d;
      end
   end

   assign col_out   = (en && !rst) ? (4'b0001 << col_idx_q) : '0;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_team_04_keypad_scanner.sv
// tb/tb_team_04_keypad_scanner.sv - keypad scanner bench with a frame-level reference model.
module tb_team_04_keypad_scanner;

   localparam int SD    = 4;
   localparam int DB    = 2;
   localparam int FRAME = 4 * SD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   logic [15:0] mat = 16'h0;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int n        = 0;
   logic live   = 1'b0;

   int         run_m    = 0;
   int         pulse_at = -1;
   logic       held_m   = 1'b0;
   logic [3:0] code_m   = 4'h0;
   logic [3:0] prev_m   = 4'h0;
   logic       fh       = 1'b0;
   logic [3:0] fc       = 4'h0;

   team_04_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its column drive onto its row line.
   always_comb begin
      row_in = 4'h0;
      for (int c = 0; c < 4; c++) begin
         if (col_out[c]) row_in = mat[c*4 +: 4];
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n    <= 0;
         live <= 1'b0;
      end else begin
         live <= en;
         n    <= en ? n + 1 : 0;
      end
   end

   always @(negedge clk) if (key_valid) pulses++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Key index is col*4+row, so the priority winner is simply the lowest pressed index.
   function automatic logic [3:0] lowest_key(input logic [15:0] m);
      for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
      return 4'h0;
   endfunction

   always @(negedge clk) begin
      logic       exp_v;
      logic [3:0] exp_col;
      exp_v   = 1'b0;
      exp_col = (en && !rst) ? (4'b0001 << ((n % FRAME) / SD)) : 4'h0;
      if (rst || !live) begin
         run_m = 0; pulse_at = -1; held_m = 1'b0; code_m = 4'h0; prev_m = 4'h0;
      end else begin
         if (n % FRAME == FRAME / 2) begin
            fh = |mat;
            fc = lowest_key(mat);
         end
         if (n > 0 && n % FRAME == 0) begin
            if (!fh) begin
               run_m = 0; held_m = 1'b0;
            end else if (run_m > 0 && fc == prev_m) begin
               run_m++;
            end else begin
               run_m = 1; held_m = 1'b0;
            end
            prev_m = fc;
            if (run_m == DB) pulse_at = n + 1;
         end
         if (n == pulse_at) begin
            exp_v = 1'b1; code_m = prev_m; held_m = 1'b1;
         end
      end
      chk("col_out", col_out, exp_col);
      chk("key_valid", key_valid, exp_v);
      chk("key_code", key_code, code_m);
      chk("key_held", key_held, held_m);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_frames(input logic [15:0] m, input int k);
      repeat (k) begin
         mat = m;
         repeat (FRAME) step();
      end
   endtask

   initial begin
      logic [3:0]  col_seq [4];
      logic [15:0] m;
      int          r;
      col_seq = '{4'h1, 4'h2, 4'h4, 4'h8};

      repeat (3) step();
      chk("rst col_out", col_out, 0);
      chk("rst key_code", key_code, 0);
      rst = 1'b0;
      repeat (3) step();
      chk("idle key_valid", key_valid, 0);

      en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("col sequence", col_out, col_seq[(i / SD) % 4]);
      end
      do step(); while (n % FRAME != 0);

      set_frames(16'h0000, 100);
      chk("no key pulses", pulses, 0);
      chk("no key held", key_held, 0);

      set_frames(16'h0040, 3);
      chk("press pulses", pulses, 1);
      chk("press code", key_code, 6);
      chk("press held", key_held, 1);
      set_frames(16'h0000, 1);
      chk("release held", key_held, 0);
      chk("release code", key_code, 6);

      set_frames(16'h010A, 3);
      chk("priority code", key_code, 1);
      chk("priority pulses", pulses, 2);
      set_frames(16'h0000, 1);

      repeat (3) begin
         set_frames(16'h0020, 1);
         set_frames(16'h0000, 1);
      end
      chk("bounce pulses", pulses, 2);
      set_frames(16'h0020, 3);
      chk("stable pulses", pulses, 3);
      chk("stable code", key_code, 5);
      set_frames(16'h8000, 3);
      chk("switch pulses", pulses, 4);
      chk("switch code", key_code, 15);
      chk("switch held", key_held, 1);

      set_frames(16'h0000, 1);
      mat = 16'h0040;
      repeat (FRAME + FRAME / 2) step();
      en = 1'b0;
      step();
      chk("abort col_out", col_out, 0);
      chk("abort key_code", key_code, 0);
      chk("abort key_held", key_held, 0);
      repeat (3 * FRAME) step();
      chk("abort pulses", pulses, 4);

      en = 1'b1;
      m  = 16'h0;
      for (int f = 0; f < 150; f++) begin
         r = $urandom_range(0, 7);
         if (r == 4) m = 16'h0;
         else if (r == 5 || r == 6) m = 16'h1 << $urandom_range(0, 15);
         else if (r == 7) m = 16'($urandom);
         set_frames(m, 1);
      end

      set_frames(16'h0000, 1);
      set_frames(16'h0200, 3);
      chk("pre-rst held", key_held, 1);
      chk("pre-rst code", key_code, 9);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst col_out", col_out, 0);
      chk("async rst key_code", key_code, 0);
      chk("async rst key_held", key_held, 0);
      chk("async rst key_valid", key_valid, 0);
      step();
      rst = 1'b0;
      en  = 1'b0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
